double_to_int16: RTL and testbench

DOUBLE_TO_INT16 -- requirements
Module: double_to_int16

---
 rtl/double_to_int16.sv | 168 ++++++++++++++++
 tb/tb_double_to_int16.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/double_to_int16.sv
//==============================================================================
// Module      : double_to_int16
// Description : Converts an IEEE-754 binary64 sample to a saturating signed
//               16-bit integer (truncation toward zero). One sample at a time,
//               valid/ready on both sides, serial right-shifter datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module double_to_int16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [10:0] c_EXP_BIAS = 11'd1023;  // E = 0
    localparam logic [10:0] c_EXP_E14  = 11'd1037;  // E = 14, largest in-range
    localparam logic [10:0] c_EXP_E15  = 11'd1038;  // E = 15, saturation starts
    localparam logic [10:0] c_EXP_MAX  = 11'h7FF;   // Inf / NaN

    state_t      r_state;
    state_t      w_next;

    logic        r_sign;
    logic [15:0] r_mag;
    logic [3:0]  r_k;
    logic        r_nan;
    logic        r_zero;
    logic        r_sat;
    logic        r_min;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        r_out_ovf;
    logic        r_out_nan;

    logic [10:0] w_exp;
    logic        w_frac_nz;
    logic        w_accept;
    logic        w_nan;
    logic        w_small;
    logic        w_sat;
    logic        w_min;
    logic        w_in_range;
    logic [3:0]  w_k;
    logic [15:0] w_res_data;
    logic        w_res_ovf;
    logic        w_res_nan;

    // Input classification, evaluated on the accept cycle only
    assign w_exp      = in_data[62:52];
    assign w_frac_nz  = |in_data[51:0];
    assign w_accept   = in_valid && in_ready;
    assign w_nan      = (w_exp == c_EXP_MAX) && w_frac_nz;
    assign w_small    = (w_exp < c_EXP_BIAS);   // zero, subnormal or |x| < 1
    assign w_sat      = !w_nan && (w_exp >= c_EXP_E15);
    assign w_min      = in_data[63] && (w_exp == c_EXP_E15) && !w_frac_nz;
    assign w_in_range = (w_exp >= c_EXP_BIAS) && (w_exp <= c_EXP_E14);
    // k = 15 - E = 1038 - exp; 1038 mod 16 = 14 so 4-bit arithmetic suffices
    assign w_k        = w_in_range ? (4'd14 - w_exp[3:0]) : 4'd0;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_nan   = r_out_nan;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT:   if (r_k == 4'd0) w_next = OUT;
            OUT:     if (r_out_valid && out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Final result selection from the shifted magnitude and the stored class
    always_comb begin
        w_res_data = 16'h0000;
        w_res_ovf  = 1'b0;
        w_res_nan  = 1'b0;
        if (r_nan) begin
            w_res_nan = 1'b1;
        end else if (r_zero) begin
            w_res_data = 16'h0000;
        end else if (r_sat) begin
            // -32768.0 is representable exactly, so it is not an overflow
            w_res_data = r_sign ? 16'h8000 : 16'h7FFF;
            w_res_ovf  = !r_min;
        end else begin
            w_res_data = r_sign ? (~r_mag + 16'd1) : r_mag;
        end
    end

    // Datapath: capture on accept, serial shift, result register with hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign      <= 1'b0;
            r_mag       <= 16'h0000;
            r_k         <= 4'd0;
            r_nan       <= 1'b0;
            r_zero      <= 1'b0;
            r_sat       <= 1'b0;
            r_min       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_ovf   <= 1'b0;
            r_out_nan   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= in_data[63];
                        r_mag  <= {1'b1, in_data[51:37]};
                        r_k    <= w_k;
                        r_nan  <= w_nan;
                        r_zero <= w_small;
                        r_sat  <= w_sat;
                        r_min  <= w_min;
                    end
                end
                SHIFT: begin
                    if (r_k != 4'd0) begin
                        r_mag <= {1'b0, r_mag[15:1]};
                        r_k   <= r_k - 4'd1;
                    end
                end
                OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res_data;
                        r_out_ovf   <= w_res_ovf;
                        r_out_nan   <= w_res_nan;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_double_to_int16.sv
//==============================================================================
// Module      : tb_double_to_int16
// Description : Self-checking bench for double_to_int16 with an expected-result
//               queue filled at stimulus time and drained at DUT output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_double_to_int16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_nan;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] d;
        logic        ovf;
        logic        nan;
        int          lat;
    } exp_t;

    typedef struct {
        logic [63:0] din;
        logic [15:0] d;
        logic        ovf;
        logic        nan;
        int          lat;
    } vec_t;

    exp_t sb[$];

    double_to_int16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample at a negedge, then count edges until out_valid shows
    task automatic do_accept(input logic [63:0] din, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 64'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_valid, out_data, out_ovf, out_nan, in_ready} !== 20'h0)
            $display("FAIL reset_outputs: got v=%b d=%h ovf=%b nan=%b rdy=%b, want all 0",
                     out_valid, out_data, out_ovf, out_nan, in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_conversions;
        vec_t vecs[12];
        exp_t e;
        int lat;
        bit ok;
        vecs = '{
            '{64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 17},  // 1.0
            '{64'hC08F400000000000, 16'hFC18, 1'b0, 1'b0, 8},   // -1000.0
            '{64'h40E0000000000000, 16'h7FFF, 1'b1, 1'b0, 2},   // 32768.0
            '{64'hC0E0000000000000, 16'h8000, 1'b0, 1'b0, 2},   // -32768.0
            '{64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0, 2},   // -Inf
            '{64'h7FF0000000000000, 16'h7FFF, 1'b1, 1'b0, 2},   // +Inf
            '{64'h3FE0000000000000, 16'h0000, 1'b0, 1'b0, 2},   // 0.5
            '{64'h8000000000000000, 16'h0000, 1'b0, 1'b0, 2},   // -0.0
            '{64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 2},   // NaN
            '{64'h40DFFFC000000000, 16'h7FFF, 1'b0, 1'b0, 3},   // 32767.0
            '{64'h400E000000000000, 16'h0003, 1'b0, 1'b0, 16},  // 3.75
            '{64'hC004000000000000, 16'hFFFE, 1'b0, 1'b0, 16}   // -2.5
        };
        foreach (vecs[i]) begin
            sb.push_back('{vecs[i].d, vecs[i].ovf, vecs[i].nan, vecs[i].lat});
            do_accept(vecs[i].din, lat, ok);
            n_total++;
            if (!ok) begin
                $display("FAIL conv_timeout[%0d]: no out_valid after %0d edges", i, lat);
                void'(sb.pop_front());
                continue;
            end
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if ({out_data, out_ovf, out_nan} !== {e.d, e.ovf, e.nan})
                $display("FAIL conv_result[%0d]: got d=%h ovf=%b nan=%b want d=%h ovf=%b nan=%b",
                         i, out_data, out_ovf, out_nan, e.d, e.ovf, e.nan);
            else n_pass++;
            n_total++;
            if (lat != e.lat)
                $display("FAIL conv_latency[%0d]: got %0d want %0d", i, lat, e.lat);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int lat;
        bit ok;
        bit stable_ok = 1'b1;
        out_ready = 1'b0;
        sb.push_back('{16'hFC18, 1'b0, 1'b0, 8});
        do_accept(64'hC08F400000000000, lat, ok);
        e = sb.pop_front();
        n_total++;
        if (!ok || out_data !== e.d || out_ovf !== e.ovf || lat != e.lat)
            $display("FAIL bp_result: got ok=%b d=%h ovf=%b lat=%0d want d=%h ovf=%b lat=%0d",
                     ok, out_data, out_ovf, lat, e.d, e.ovf, e.lat);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== e.d || out_ovf !== 1'b0 ||
                out_nan !== 1'b0 || in_ready !== 1'b0) begin
                stable_ok = 1'b0;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ovf=%b nan=%b rdy=%b want v=1 d=%h ovf=0 nan=0 rdy=0",
                         i, out_valid, out_data, out_ovf, out_nan, in_ready, e.d);
            end
        end
        n_total++;
        if (stable_ok) n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int lat;
        bit ok;
        bit seen = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h3FF0000000000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_data, out_ovf, out_nan, in_ready} !== 20'h0)
            $display("FAIL abort_outputs: got v=%b d=%h ovf=%b nan=%b rdy=%b want all 0",
                     out_valid, out_data, out_ovf, out_nan, in_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", in_ready);
        else n_pass++;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL abort_no_valid: got out_valid pulse, want none");
        else n_pass++;
        sb.push_back('{16'h0001, 1'b0, 1'b0, 17});
        do_accept(64'h3FF0000000000000, lat, ok);
        e = sb.pop_front();
        n_total++;
        if (!ok || out_data !== e.d || out_ovf !== e.ovf || out_nan !== e.nan || lat != e.lat)
            $display("FAIL abort_next: got ok=%b d=%h ovf=%b nan=%b lat=%0d want d=%h ovf=%b nan=%b lat=%0d",
                     ok, out_data, out_ovf, out_nan, lat, e.d, e.ovf, e.nan, e.lat);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_conversions;
        test_backpressure;
        test_reset_abort;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
